// File: rtl/me_window_scheduler.sv
// me_window_scheduler
//   Command sequencer for fixed-window, left-to-right modular exponentiation.
//   The exponent is scanned from its MSB in WIN-bit windows. The scheduler
//   issues LOAD / SQR / MUL / LOAD_ONE commands to a shared modular
//   multiplier, with only one command outstanding at a time. Operands come
//   from a precomputed power table (base^0 .. base^(2^WIN-1)). No operand
//   data passes through this block.
//
// Ports
//   clk, rst        rising-edge clock, synchronous active-high reset
//   start, e        one-cycle request and exponent; only accepted in IDLE
//   tbl_ready       power table precomputed and readable
//   cmd_valid/ready command handshake toward the multiplier
//   cmd_op          0=LOAD 1=SQR 2=MUL 3=LOAD_ONE
//   cmd_idx         table index for LOAD/MUL, 0 otherwise
//   op_done         pulse: the accepted command has finished
//   busy            sequence in progress (cycle after start until done)
//   done            pulse: exponentiation sequence complete
module me_window_scheduler #(
    parameter int WIDTH = 3072,
    parameter int WIN   = 2,
    parameter int NW_W  = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] e,
    input  logic             tbl_ready,
    output logic             cmd_valid,
    input  logic             cmd_ready,
    output logic [1:0]       cmd_op,
    output logic [WIN-1:0]   cmd_idx,
    input  logic             op_done,
    output logic             busy,
    output logic             done
);
    localparam logic [1:0] OP_LOAD = 2'd0;
    localparam logic [1:0] OP_SQR  = 2'd1;
    localparam logic [1:0] OP_MUL  = 2'd2;
    localparam logic [1:0] OP_ONE  = 2'd3;

    localparam int SQ_W = (WIN > 1) ? $clog2(WIN) : 1;
    localparam logic [NW_W-1:0] NWIN      = NW_W'(WIDTH / WIN);
    localparam logic [SQ_W-1:0] SQ_RELOAD = SQ_W'(WIN - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_TBL,
        S_SCAN,
        S_ISSUE,
        S_WAIT_OP,
        S_NEXT,
        S_FIN
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] esr_q;
    logic [NW_W-1:0]  win_cnt_q;
    logic [SQ_W-1:0]  sq_cnt_q;
    logic             cmd_valid_q;
    logic [1:0]       cmd_op_q;
    logic [WIN-1:0]   cmd_idx_q;
    logic             busy_q;
    logic             done_q;

    logic [WIN-1:0]   w;
    logic             last_win;
    logic [WIDTH-1:0] esr_shift_d;
    logic [NW_W-1:0]  win_cnt_dec_d;

    // Current window is always the top WIN bits of the shift register.
    assign w             = esr_q[WIDTH-1 -: WIN];
    assign last_win      = (win_cnt_q == NW_W'(1));
    assign esr_shift_d   = esr_q << WIN;
    assign win_cnt_dec_d = win_cnt_q - NW_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            esr_q       <= '0;
            win_cnt_q   <= '0;
            sq_cnt_q    <= '0;
            cmd_valid_q <= 1'b0;
            cmd_op_q    <= OP_LOAD;
            cmd_idx_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        esr_q     <= e;
                        win_cnt_q <= NWIN;
                        sq_cnt_q  <= '0;
                        busy_q    <= 1'b1;
                        // With the table already readable the wait for it
                        // is satisfied in the start cycle, so the scan begins
                        // immediately.
                        state_q   <= tbl_ready ? S_SCAN : S_WAIT_TBL;
                    end
                end
                S_WAIT_TBL: begin
                    if (tbl_ready) begin
                        state_q <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    if (w == '0) begin
                        // Leading zero window: skip it without any command.
                        esr_q     <= esr_shift_d;
                        win_cnt_q <= win_cnt_dec_d;
                        if (last_win) begin
                            cmd_valid_q <= 1'b1;
                            cmd_op_q    <= OP_ONE;
                            cmd_idx_q   <= '0;
                            state_q     <= S_ISSUE;
                        end
                    end else begin
                        cmd_valid_q <= 1'b1;
                        cmd_op_q    <= OP_LOAD;
                        cmd_idx_q   <= w;
                        state_q     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (cmd_ready) begin
                        cmd_valid_q <= 1'b0;
                        state_q     <= S_WAIT_OP;
                    end
                end
                S_WAIT_OP: begin
                    if (op_done) begin
                        state_q <= S_NEXT;
                    end
                end
                S_NEXT: begin
                    if (sq_cnt_q != '0) begin
                        sq_cnt_q    <= sq_cnt_q - SQ_W'(1);
                        cmd_valid_q <= 1'b1;
                        cmd_op_q    <= OP_SQR;
                        cmd_idx_q   <= '0;
                        state_q     <= S_ISSUE;
                    end else if (cmd_op_q == OP_SQR && w != '0) begin
                        // Square run for this window finished; fold in the
                        // window's table entry.
                        cmd_valid_q <= 1'b1;
                        cmd_op_q    <= OP_MUL;
                        cmd_idx_q   <= w;
                        state_q     <= S_ISSUE;
                    end else begin
                        // Window complete (after LOAD, MUL, or squares of a
                        // zero window): advance to the next window.
                        esr_q     <= esr_shift_d;
                        win_cnt_q <= win_cnt_dec_d;
                        if (last_win || cmd_op_q == OP_ONE) begin
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= S_FIN;
                        end else begin
                            // First square issued now, WIN-1 more pending.
                            sq_cnt_q    <= SQ_RELOAD;
                            cmd_valid_q <= 1'b1;
                            cmd_op_q    <= OP_SQR;
                            cmd_idx_q   <= '0;
                            state_q     <= S_ISSUE;
                        end
                    end
                end
                S_FIN: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign cmd_valid = cmd_valid_q;
    assign cmd_op    = cmd_op_q;
    assign cmd_idx   = cmd_idx_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_me_window_scheduler.sv
// Testbench for me_window_scheduler (WIDTH=8, WIN=2). A multiplier responder
// accepts commands and returns op_done after a chosen latency; the recorded
// command stream is compared against a window-by-window reference model.
module tb_me_window_scheduler;
    localparam int W      = 8;
    localparam int WN     = 2;
    localparam int MAXCYC = 3000;

    localparam logic [1:0] OP_LOAD = 2'd0;
    localparam logic [1:0] OP_SQR  = 2'd1;
    localparam logic [1:0] OP_MUL  = 2'd2;
    localparam logic [1:0] OP_ONE  = 2'd3;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [W-1:0]  e;
    logic          tbl_ready;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_op;
    logic [WN-1:0] cmd_idx;
    logic          op_done;
    logic          busy;
    logic          done;

    me_window_scheduler #(.WIDTH(W), .WIN(WN), .NW_W(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .e         (e),
        .tbl_ready (tbl_ready),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_idx   (cmd_idx),
        .op_done   (op_done),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [3:0] got_q[$];
    logic [3:0] exp_q[$];
    int   n_done, first_vld, last_opd, done_step, stab_err, busy_gap, timeout, post_act;
    logic busy_at_done, busy_after;
    logic [6:0] rst_outs;

    // Reference: skip leading zero windows, LOAD the first nonzero window,
    // then WN squares per later window plus a MUL when that window is nonzero.
    function automatic void build_model(input logic [W-1:0] ev);
        bit started;
        logic [1:0] wv;
        started = 0;
        exp_q.delete();
        for (int i = W / WN - 1; i >= 0; i--) begin
            wv = ev[i*WN +: WN];
            if (!started) begin
                if (wv != 2'd0) begin
                    started = 1;
                    exp_q.push_back({OP_LOAD, wv});
                end
            end else begin
                for (int s = 0; s < WN; s++) exp_q.push_back({OP_SQR, 2'd0});
                if (wv != 2'd0) exp_q.push_back({OP_MUL, wv});
            end
        end
        if (!started) exp_q.push_back({OP_ONE, 2'd0});
    endfunction

    function automatic int stream_diff();
        int d;
        d = (got_q.size() > exp_q.size()) ? got_q.size() - exp_q.size()
                                          : exp_q.size() - got_q.size();
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            if (got_q[i] !== exp_q[i]) d++;
        return d;
    endfunction

    function automatic int count_op(input logic [1:0] op);
        int n;
        n = 0;
        foreach (got_q[i]) if (got_q[i][3:2] == op) n++;
        return n;
    endfunction

    // Drives one start and plays the multiplier; step N is observed 1 time
    // unit after the N-th clock edge following the start drive.
    task automatic run_seq(input logic [W-1:0] ev, input int lat_min, input int lat_max,
                           input bit rnd_rdy, input int tbl_delay, input int hold_low,
                           input bit spur, input int abort_cmd);
        int step, pend, hold_cnt, abort_step, lat;
        bit ended, was_wait, r;
        logic [1:0] hold_op;
        logic [1:0] hold_idx;
        got_q.delete();
        n_done = 0; first_vld = -1; last_opd = -1; done_step = -1;
        stab_err = 0; busy_gap = 0; timeout = 0; post_act = 0;
        busy_at_done = 1'bx; busy_after = 1'bx; rst_outs = 'x;
        pend = 0; hold_cnt = 0; abort_step = -1; was_wait = 0;
        hold_op = 2'd0; hold_idx = 2'd0;
        start = 1'b1; e = ev; tbl_ready = (tbl_delay == 0);
        cmd_ready = 1'b0; op_done = 1'b0; rst = 1'b0;
        ended = 0; step = 0;
        while (!ended) begin
            @(posedge clk); #1;
            step++;
            start = 1'b0; op_done = 1'b0; cmd_ready = 1'b0; rst = 1'b0;
            tbl_ready = (step >= tbl_delay);
            if (spur && step == 3) begin start = 1'b1; e = ~ev; end
            if (cmd_valid && first_vld < 0) first_vld = step;
            if (was_wait && (cmd_valid !== 1'b1 || cmd_op !== hold_op || cmd_idx !== hold_idx))
                stab_err++;
            if (done === 1'b1) begin
                n_done++;
                if (done_step < 0) begin done_step = step; busy_at_done = busy; end
            end
            if (done_step < 0 && abort_step < 0 && busy !== 1'b1) busy_gap++;
            if (abort_step >= 0 && step == abort_step) rst = 1'b1;
            if (abort_step >= 0 && step == abort_step + 1)
                rst_outs = {cmd_valid, cmd_op, cmd_idx, busy, done};
            if (abort_step >= 0 && step > abort_step && (cmd_valid || busy || done)) post_act++;
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin op_done = 1'b1; last_opd = step; end
            end
            was_wait = 0;
            if (cmd_valid === 1'b1) begin
                if (hold_cnt < hold_low) begin r = 0; hold_cnt++; end
                else r = rnd_rdy ? ($urandom_range(0, 2) != 0) : 1'b1;
                cmd_ready = r;
                if (r) begin
                    got_q.push_back({cmd_op, cmd_idx});
                    lat = int'($urandom_range(lat_min, lat_max));
                    pend = lat;
                    if (spur) op_done = 1'b1;
                    if (abort_cmd > 0 && got_q.size() == abort_cmd) abort_step = step + 1;
                end else begin
                    was_wait = 1; hold_op = cmd_op; hold_idx = cmd_idx;
                end
            end
            if (done_step >= 0 && step == done_step + 3) begin busy_after = busy; ended = 1; end
            if (abort_step >= 0 && step == abort_step + 10) ended = 1;
            if (step > MAXCYC) begin timeout = 1; ended = 1; end
        end
        start = 1'b0; cmd_ready = 1'b0; op_done = 1'b0; rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total++; if (cmd_valid !== 1'b0) begin bad++; $display("FAIL reset_cmd_valid: got %b want 0", cmd_valid); end
        total++; if (cmd_op !== 2'd0) begin bad++; $display("FAIL reset_cmd_op: got %0d want 0", cmd_op); end
        total++; if (cmd_idx !== 2'd0) begin bad++; $display("FAIL reset_cmd_idx: got %0d want 0", cmd_idx); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done); end
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL idle_busy: got %b want 0", busy); end
    endtask

    task automatic test_basic();
        build_model(8'b10101110);
        run_seq(8'b10101110, 3, 3, 0, 0, 0, 0, 0);
        total++; if (timeout !== 0) begin bad++; $display("FAIL basic_timeout: got %0d want 0", timeout); end
        total++; if (got_q.size() !== 10) begin bad++; $display("FAIL basic_count: got %0d want 10", got_q.size()); end
        total++; if (stream_diff() !== 0) begin bad++; $display("FAIL basic_stream: got %0d diffs want 0", stream_diff()); end
        total++; if (n_done !== 1) begin bad++; $display("FAIL basic_done_cnt: got %0d want 1", n_done); end
        total++; if (first_vld !== 2) begin bad++; $display("FAIL basic_first_cmd: got step %0d want 2", first_vld); end
        total++; if (done_step - last_opd !== 2) begin bad++; $display("FAIL basic_done_lat: got %0d want 2", done_step - last_opd); end
        total++; if (busy_gap !== 0) begin bad++; $display("FAIL basic_busy_gap: got %0d want 0", busy_gap); end
        total++; if (busy_at_done !== 1'b0) begin bad++; $display("FAIL basic_busy_at_done: got %b want 0", busy_at_done); end
        total++; if (busy_after !== 1'b0) begin bad++; $display("FAIL basic_busy_after: got %b want 0", busy_after); end
    endtask

    task automatic test_zero_windows();
        build_model(8'h00);
        run_seq(8'h00, 3, 3, 0, 0, 0, 0, 0);
        total++; if (timeout !== 0) begin bad++; $display("FAIL zero_timeout: got %0d want 0", timeout); end
        total++; if (got_q.size() !== 1 || got_q[0] !== {OP_ONE, 2'd0}) begin
            bad++; $display("FAIL zero_load_one: got n=%0d first=%h want n=1 first=c", got_q.size(), got_q.size() > 0 ? got_q[0] : 4'hx); end
        total++; if (n_done !== 1) begin bad++; $display("FAIL zero_done_cnt: got %0d want 1", n_done); end
        build_model(8'h01);
        run_seq(8'h01, 3, 3, 0, 0, 0, 0, 0);
        total++; if (first_vld !== 5) begin bad++; $display("FAIL one_first_cmd: got step %0d want 5", first_vld); end
        total++; if (stream_diff() !== 0) begin bad++; $display("FAIL one_stream: got %0d diffs want 0", stream_diff()); end
        total++; if (n_done !== 1) begin bad++; $display("FAIL one_done_cnt: got %0d want 1", n_done); end
    endtask

    task automatic test_no_mul();
        build_model(8'b01000000);
        run_seq(8'b01000000, 3, 3, 0, 0, 0, 0, 0);
        total++; if (timeout !== 0) begin bad++; $display("FAIL nomul_timeout: got %0d want 0", timeout); end
        total++; if (stream_diff() !== 0) begin bad++; $display("FAIL nomul_stream: got %0d diffs want 0", stream_diff()); end
        total++; if (count_op(OP_SQR) !== 6) begin bad++; $display("FAIL nomul_sqr: got %0d want 6", count_op(OP_SQR)); end
        total++; if (count_op(OP_MUL) !== 0) begin bad++; $display("FAIL nomul_mul: got %0d want 0", count_op(OP_MUL)); end
        total++; if (done_step - last_opd !== 2) begin bad++; $display("FAIL nomul_done_lat: got %0d want 2", done_step - last_opd); end
    endtask

    task automatic test_stall();
        build_model(8'b10101110);
        run_seq(8'b10101110, 3, 3, 0, 20, 5, 0, 0);
        total++; if (timeout !== 0) begin bad++; $display("FAIL stall_timeout: got %0d want 0", timeout); end
        total++; if (first_vld !== 22) begin bad++; $display("FAIL stall_first_cmd: got step %0d want 22", first_vld); end
        total++; if (busy_gap !== 0) begin bad++; $display("FAIL stall_busy_gap: got %0d want 0", busy_gap); end
        total++; if (stab_err !== 0) begin bad++; $display("FAIL stall_stable: got %0d changes want 0", stab_err); end
        total++; if (stream_diff() !== 0) begin bad++; $display("FAIL stall_stream: got %0d diffs want 0", stream_diff()); end
        total++; if (n_done !== 1) begin bad++; $display("FAIL stall_done_cnt: got %0d want 1", n_done); end
    endtask

    task automatic test_spurious();
        op_done = 1'b1;
        @(posedge clk); #1;
        op_done = 1'b0;
        @(posedge clk); #1;
        total++; if (busy !== 1'b0 || cmd_valid !== 1'b0) begin
            bad++; $display("FAIL idle_op_done: got busy=%b valid=%b want 0 0", busy, cmd_valid); end
        build_model(8'b10101110);
        run_seq(8'b10101110, 3, 3, 0, 0, 0, 1, 0);
        total++; if (timeout !== 0) begin bad++; $display("FAIL spur_timeout: got %0d want 0", timeout); end
        total++; if (stream_diff() !== 0) begin bad++; $display("FAIL spur_stream: got %0d diffs want 0", stream_diff()); end
        total++; if (n_done !== 1) begin bad++; $display("FAIL spur_done_cnt: got %0d want 1", n_done); end
    endtask

    task automatic test_abort();
        run_seq(8'b10101110, 3, 3, 0, 0, 0, 0, 4);
        total++; if (rst_outs !== 7'd0) begin bad++; $display("FAIL abort_outputs: got %b want 0000000", rst_outs); end
        total++; if (post_act !== 0) begin bad++; $display("FAIL abort_activity: got %0d want 0", post_act); end
        total++; if (n_done !== 0) begin bad++; $display("FAIL abort_done: got %0d want 0", n_done); end
        total++; if (got_q.size() !== 4) begin bad++; $display("FAIL abort_cmds: got %0d want 4", got_q.size()); end
        build_model(8'h01);
        run_seq(8'h01, 3, 3, 0, 0, 0, 0, 0);
        total++; if (timeout !== 0) begin bad++; $display("FAIL restart_timeout: got %0d want 0", timeout); end
        total++; if (stream_diff() !== 0) begin bad++; $display("FAIL restart_stream: got %0d diffs want 0", stream_diff()); end
        total++; if (n_done !== 1) begin bad++; $display("FAIL restart_done_cnt: got %0d want 1", n_done); end
    endtask

    task automatic test_random();
        logic [W-1:0] ev;
        for (int k = 0; k < 24; k++) begin
            ev = W'($urandom_range(0, 255));
            build_model(ev);
            run_seq(ev, 1, 4, 1, 0, 0, 0, 0);
            total++; if (timeout !== 0) begin bad++; $display("FAIL rnd_timeout e=%h: got %0d want 0", ev, timeout); end
            total++; if (stream_diff() !== 0) begin bad++; $display("FAIL rnd_stream e=%h: got %0d diffs want 0", ev, stream_diff()); end
            total++; if (n_done !== 1) begin bad++; $display("FAIL rnd_done_cnt e=%h: got %0d want 1", ev, n_done); end
            total++; if (done_step - last_opd !== 2) begin bad++; $display("FAIL rnd_done_lat e=%h: got %0d want 2", ev, done_step - last_opd); end
            total++; if (stab_err !== 0) begin bad++; $display("FAIL rnd_stable e=%h: got %0d want 0", ev, stab_err); end
            total++; if (busy_gap !== 0) begin bad++; $display("FAIL rnd_busy_gap e=%h: got %0d want 0", ev, busy_gap); end
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; e = '0; tbl_ready = 1'b0;
        cmd_ready = 1'b0; op_done = 1'b0;
        test_reset();
        test_basic();
        test_zero_windows();
        test_no_mul();
        test_stall();
        test_spurious();
        test_abort();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
